// File: rtl/opl3_i2s_tx.sv
// Stereo sample FIFO plus Philips I2S serializer (BCLK/LRCK/SDATA) in the core clock domain.
// Define OPL3_I2S_UNDERRUN_REPEAT_EN to retransmit the previous frame on underrun instead of silence.
module opl3_i2s_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              ic_n,
  input  logic                              sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]           sample_l,
  input  logic [SAMPLE_WIDTH-1:0]           sample_r,
  input  logic                              clr_flags,
  output logic                              i2s_bclk,
  output logic                              i2s_lrck,
  output logic                              i2s_sdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              underrun,
  output logic                              overflow
);

  localparam int FRAME_W = 2 * SLOT_WIDTH;
  localparam int N_W     = $clog2(FRAME_W);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = 2 * SAMPLE_WIDTH;
  localparam int PAD_W   = SLOT_WIDTH - SAMPLE_WIDTH;

  logic [DIV_W-1:0]   div_reg;
  logic               bclk_reg;
  logic               div_tc;
  logic               fall_evt;
  logic [N_W-1:0]     n_reg;
  logic [N_W-1:0]     n_next;
  logic               frame_load;
  logic               lrck_reg;
  logic               sdata_reg;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] load_word;
  logic [FRAME_W-1:0] fill_word;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [SAMPLE_WIDTH-1:0] head_l;
  logic [SAMPLE_WIDTH-1:0] head_r;
  logic [SLOT_WIDTH-1:0]   slot_l;
  logic [SLOT_WIDTH-1:0]   slot_r;

  logic underrun_reg;
  logic overflow_reg;
  logic underrun_set;
  logic overflow_set;

  // Bit clock divider: a 1->0 toggle is the single event that advances the serializer.
  assign div_tc   = (div_reg == DIV_W'(BCLK_DIV - 1));
  assign fall_evt = div_tc & bclk_reg;

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      div_reg  <= '0;
      bclk_reg <= 1'b0;
    end else if (div_tc) begin
      div_reg  <= '0;
      bclk_reg <= ~bclk_reg;
    end else begin
      div_reg  <= div_reg + 1'b1;
    end
  end

  assign n_next     = (n_reg == N_W'(FRAME_W - 1)) ? '0 : n_reg + 1'b1;
  assign frame_load = fall_evt & (n_next == '0);

  // FIFO control; a pop on the load cycle frees the slot a same-cycle push needs.
  assign fifo_empty   = (level_reg == '0);
  assign fifo_full    = (level_reg == LVL_W'(FIFO_DEPTH));
  assign pop          = frame_load & ~fifo_empty;
  assign push         = sample_valid & (~fifo_full | pop);
  assign overflow_set = sample_valid & fifo_full & ~pop;
  assign underrun_set = frame_load & fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {sample_l, sample_r};
    end
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Shallow FIFO is read asynchronously so the head is available on the load cycle itself.
  assign head   = fifo_mem[rd_ptr_reg];
  assign head_l = head[ENTRY_W-1:SAMPLE_WIDTH];
  assign head_r = head[SAMPLE_WIDTH-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < SLOT_WIDTH; gi++) begin : g_slot
      if (gi >= PAD_W) begin : g_data
        assign slot_l[gi] = head_l[gi-PAD_W];
        assign slot_r[gi] = head_r[gi-PAD_W];
      end else begin : g_pad
        assign slot_l[gi] = 1'b0;
        assign slot_r[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef OPL3_I2S_UNDERRUN_REPEAT_EN
  logic [FRAME_W-1:0] last_frame_reg;

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      last_frame_reg <= '0;
    end else if (frame_load) begin
      last_frame_reg <= load_word;
    end
  end

  assign fill_word = last_frame_reg;
`else
  assign fill_word = '0;
`endif

  always_comb begin
    load_word = fill_word;
    if (!fifo_empty) begin
      load_word = {slot_l, slot_r};
    end
  end

  // sdata_reg is the one-BCLK I2S delay: it carries the previous frame's LSB at n=0.
  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      n_reg     <= N_W'(FRAME_W - 1);
      lrck_reg  <= 1'b0;
      sdata_reg <= 1'b0;
      shift_reg <= '0;
    end else if (fall_evt) begin
      n_reg     <= n_next;
      lrck_reg  <= (n_next >= N_W'(SLOT_WIDTH));
      sdata_reg <= shift_reg[FRAME_W-1];
      if (n_next == '0) begin
        shift_reg <= load_word;
      end else begin
        shift_reg <= shift_reg << 1;
      end
    end
  end

  // Sticky flags: a set event on the same cycle as clr_flags keeps the flag high.
  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      underrun_reg <= underrun_set | (underrun_reg & ~clr_flags);
      overflow_reg <= overflow_set | (overflow_reg & ~clr_flags);
    end
  end

  assign i2s_bclk   = bclk_reg;
  assign i2s_lrck   = lrck_reg;
  assign i2s_sdata  = sdata_reg;
  assign fifo_level = level_reg;
  assign underrun   = underrun_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_opl3_i2s_tx.sv
// Directed bench for opl3_i2s_tx: decodes the serial stream frame by frame against hand-built words.
`timescale 1ns/1ps
module tb_opl3_i2s_tx;

  logic        clk = 1'b0;
  logic        ic_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_l = '0;
  logic [23:0] sample_r = '0;
  logic        clr_flags = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int tb_n = 63;
  int fall_cnt = 0;

`ifdef OPL3_I2S_UNDERRUN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  localparam logic [63:0] LR_WORD = 64'h0000_0001_FFFF_FFFE;

  opl3_i2s_tx #(
    .SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .ic_n(ic_n), .sample_valid(sample_valid),
    .sample_l(sample_l), .sample_r(sample_r), .clr_flags(clr_flags),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .fifo_level(fifo_level), .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Slot position as the DAC sees it: one step per falling BCLK.
  always @(negedge i2s_bclk or negedge ic_n) begin
    if (!ic_n) begin
      tb_n = 63;
    end else begin
      tb_n = (tb_n == 63) ? 0 : tb_n + 1;
      fall_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  function automatic logic [63:0] underrun_fill(input logic [63:0] prev);
    return REPEAT ? prev : 64'h0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_fall();
    int start = fall_cnt;
    bit ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (fall_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    check("bclk_fall_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_n(input int target);
    int start = fall_cnt;
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (fall_cnt != start && tb_n == target) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_slot_pos", 64'(ok), 64'd1);
  endtask

  task automatic capture(output logic [63:0] d, output logic [63:0] lr);
    d  = '0;
    lr = '0;
    for (int k = 1; k <= 64; k++) begin
      next_fall();
      d  = {d[62:0], i2s_sdata};
      lr = {lr[62:0], i2s_lrck};
    end
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
  endtask

  logic [63:0] d, lr;
  time t0, t1;
  logic [23:0] st_l [100];
  logic [23:0] st_r [100];
  logic [23:0] ov_l [7];
  logic [23:0] ov_r [7];
  int phase;

  initial begin
    // Reset and idle
    repeat (5) @(posedge clk);
    #1;
    check("rst_bclk", 64'(i2s_bclk), 64'd0);
    check("rst_lrck", 64'(i2s_lrck), 64'd0);
    check("rst_sdata", 64'(i2s_sdata), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    ic_n = 1'b1;
    wait_n(0);
    t0 = $time;
    check("idle_underrun", 64'(underrun), 64'd1);
    check("idle_level", 64'(fifo_level), 64'd0);
    check("idle_lrck_n0", 64'(i2s_lrck), 64'd0);
    next_fall();
    t1 = $time;
    check("bclk_period", 64'(t1 - t0), 64'd40);
    wait_n(0);
    capture(d, lr);
    check("idle_frame", d, 64'h0);
    check("idle_lrck_pattern", lr, LR_WORD);
    wait_n(32);
    t0 = $time;
    check("lrck_high_n32", 64'(i2s_lrck), 64'd1);
    wait_n(32);
    t1 = $time;
    check("lrck_period", 64'(t1 - t0), 64'd2560);

    // Single frame
    push(24'h800001, 24'h7FFFFE);
    check("single_level_after_push", 64'(fifo_level), 64'd1);
    pulse_clr();
    check("single_underrun_cleared", 64'(underrun), 64'd0);
    wait_n(0);
    check("single_level_after_pop", 64'(fifo_level), 64'd0);
    check("single_no_underrun", 64'(underrun), 64'd0);
    capture(d, lr);
    check("single_frame", d, 64'h80000100_7FFFFE00);
    check("single_lrck_pattern", lr, LR_WORD);
    check("single_empty_underrun", 64'(underrun), 64'd1);

    // Steady stream, one sample per frame at a random phase
    for (int i = 0; i < 100; i++) begin
      st_l[i] = 24'($urandom);
      st_r[i] = 24'($urandom);
    end
    phase = $urandom_range(1, 250);
    fork
      begin
        repeat (phase - 1) @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
          if (i > 0) begin
            repeat (255) @(posedge clk);
            #1;
          end
          push(st_l[i], st_r[i]);
        end
      end
      begin
        logic [63:0] sd, slr;
        capture(sd, slr);
        check("stream_lead_frame", sd, underrun_fill(64'h80000100_7FFFFE00));
        pulse_clr();
        for (int i = 0; i < 100; i++) begin
          check("stream_underrun", 64'(underrun), 64'd0);
          check("stream_overflow", 64'(overflow), 64'd0);
          check("stream_level_le2", 64'(fifo_level <= 3'd2), 64'd1);
          capture(sd, slr);
          check("stream_frame", sd, frame_of(st_l[i], st_r[i]));
        end
      end
    join
    check("stream_tail_underrun", 64'(underrun), 64'd1);

    // Overflow, clear-vs-set priority and full-FIFO push/pop collision
    for (int i = 0; i < 7; i++) begin
      ov_l[i] = 24'h100000 + 24'(i * 24'h011111);
      ov_r[i] = 24'hF00000 - 24'(i * 24'h001234);
    end
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      push(ov_l[i], ov_r[i]);
    end
    check("ovf_level_full", 64'(fifo_level), 64'd4);
    check("ovf_flag_set", 64'(overflow), 64'd1);
    clr_flags = 1'b1;
    push(24'hDEAD00, 24'hBEEF00);
    clr_flags = 1'b0;
    check("ovf_clr_vs_set", 64'(overflow), 64'd1);
    check("ovf_level_kept", 64'(fifo_level), 64'd4);
    pulse_clr();
    check("ovf_cleared", 64'(overflow), 64'd0);
    wait_n(63);
    repeat (3) @(posedge clk);
    #1;
    push(ov_l[6], ov_r[6]);
    check("collide_on_load", 64'(tb_n), 64'd0);
    check("collide_level", 64'(fifo_level), 64'd4);
    check("collide_overflow", 64'(overflow), 64'd0);
    check("collide_underrun", 64'(underrun), 64'd0);
    for (int i = 0; i < 5; i++) begin
      capture(d, lr);
      check("ovf_frame", d, (i < 4) ? frame_of(ov_l[i], ov_r[i]) : frame_of(ov_l[6], ov_r[6]));
    end
    check("ovf_drain_level", 64'(fifo_level), 64'd0);
    check("ovf_drain_underrun", 64'(underrun), 64'd1);

    // Asynchronous reset mid-frame, then clean restart
    push(24'hFFFFFF, 24'h123456);
    push(24'h000001, 24'h000002);
    check("pre_rst_level", 64'(fifo_level), 64'd2);
    wait_n(0);
    wait_n(17);
    repeat (2) @(posedge clk);
    #3;
    check("pre_rst_bclk", 64'(i2s_bclk), 64'd1);
    check("pre_rst_sdata", 64'(i2s_sdata), 64'd1);
    check("pre_rst_level", 64'(fifo_level), 64'd1);
    ic_n = 1'b0;
    #1;
    check("async_rst_bclk", 64'(i2s_bclk), 64'd0);
    check("async_rst_sdata", 64'(i2s_sdata), 64'd0);
    check("async_rst_lrck", 64'(i2s_lrck), 64'd0);
    check("async_rst_level", 64'(fifo_level), 64'd0);
    check("async_rst_underrun", 64'(underrun), 64'd0);
    check("async_rst_overflow", 64'(overflow), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ic_n = 1'b1;
    push(24'h5A5A5A, 24'hA5A5A5);
    check("restart_level", 64'(fifo_level), 64'd1);
    wait_n(0);
    check("restart_no_underrun", 64'(underrun), 64'd0);
    check("restart_level_popped", 64'(fifo_level), 64'd0);
    capture(d, lr);
    check("restart_frame", d, frame_of(24'h5A5A5A, 24'hA5A5A5));
    check("restart_lrck_pattern", lr, LR_WORD);
    check("restart_underrun", 64'(underrun), 64'd1);
    capture(d, lr);
    check("underrun_frame", d, underrun_fill(frame_of(24'h5A5A5A, 24'hA5A5A5)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opl3_i2s_tx.md
Name: opl3_i2s_tx

Overview:
- Downstream consumer of the OPL3 core's stereo sample stream (sample_valid strobe plus signed 24-bit left/right).
- Buffers samples in a small stereo FIFO and serializes them as a standard Philips I2S stream (BCLK/LRCK/SDATA) for an external DAC.
- Runs entirely in the core clock domain, with BCLK derived by integer division.
- With clk ≈ 256 × Fs and BCLK_DIV=2, one 64-bit frame is exactly 256 clk. The FIFO absorbs phase offset between the sample strobe and the frame boundary.

Parameters:
- SAMPLE_WIDTH, 24, bits per channel sample (≤ SLOT_WIDTH).
- SLOT_WIDTH, 32, BCLK periods per channel slot; frame = 2*SLOT_WIDTH.
- BCLK_DIV, 2, clk cycles per BCLK half-period (≥1).
- FIFO_DEPTH, 4, stereo entries buffered (power of 2, ≥2).

Ports:
- clk  in  1  core clock
- ic_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe; sample_l/sample_r valid
- sample_l  in  SAMPLE_WIDTH  signed left sample
- sample_r  in  SAMPLE_WIDTH  signed right sample
- clr_flags  in  1  synchronous clear of sticky flags
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select (0 = left, 1 = right)
- i2s_sdata  out  1  serial data, MSB first
- fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held
- underrun  out  1  sticky: frame started with FIFO empty
- overflow  out  1  sticky: sample_valid dropped because FIFO full

Behaviour:
- Reset (ic_n low, async): i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, fifo_level=0, underrun=0, overflow=0, divider=0, bit counter n=2*SLOT_WIDTH-1, shift/frame registers=0.
- Divider: counts 0..BCLK_DIV-1; at terminal count, i2s_bclk toggles. A 1→0 toggle is a "fall event"; all serial outputs update only on fall events, so they are stable at the DAC's rising-edge sample.
- On each fall event, n increments modulo 2*SLOT_WIDTH.
- i2s_lrck = (n ≥ SLOT_WIDTH) after the update.
- Frame word F = {sample_l, zeros(SLOT_WIDTH-SAMPLE_WIDTH), sample_r, zeros}, transmitted MSB first.
- i2s_sdata at slot position n = F[bit n-1], i.e. the I2S one-BCLK delay: left MSB at n=1, right MSB at n=SLOT_WIDTH+1, right LSB at n=0 of the following frame (driven from a one-bit delay register).
- Frame load at the fall event producing n=0:
  - FIFO non-empty: pop head into F.
  - FIFO empty: F=0, underrun set.
- FIFO write: a sample_valid cycle pushes {sample_l, sample_r}; fifo_level updates the next cycle (1-cycle latency).
- Full with no pop that cycle: sample dropped, overflow set, contents untouched.
- Push and pop in the same cycle: both succeed, level unchanged; this includes the full case.
- Pointers wrap modulo FIFO_DEPTH.
- clr_flags clears both sticky flags. A simultaneous set event wins (flag stays 1).
- End-to-end latency: sample_valid into an empty FIFO reaches the left MSB at the first n=1 following the next frame load.

Optional Feature:
- Macro OPL3_I2S_UNDERRUN_REPEAT_EN.
- Defined: on underrun, the previous frame word F is retransmitted instead of zeros; underrun is still set. A post-reset underrun repeats the reset value 0.
- Undefined: an underrun frame is all zeros.

Test Plan:
- Reset/idle: hold ic_n low 5 cycles, release, no samples -> bclk period 4 clk, lrck period 256 clk, sdata=0 throughout, underrun=1 after first frame load, fifo_level=0.
- Single frame: push L=0x800001, R=0x7FFFFE before n=0 -> sdata decodes left slot 0x80000100 (MSB at n=1), right slot 0x7FFFFE00; lrck rises at n=32; fifo_level returns 0 after the pop.
- Steady stream: sample_valid every 256 clk at a random phase for 100 frames -> every sample emitted in order, fifo_level ≤ 2, overflow=0, underrun=0 after the first valid frame.
- Overflow: 6 strobes back-to-back before any frame load -> fifo_level=4, overflow=1, first 4 samples transmitted and the last 2 dropped.
- Push/pop collision with FIFO full: strobe on the exact pop cycle -> level stays 4, overflow=0; clr_flags pulse clears flags; clr_flags on a set cycle leaves the flag at 1.
- Async reset mid-frame at n=17 -> outputs zero immediately (combinationally from ic_n); after release the first frame begins cleanly at n=0; run under both macro settings (repeat vs zero underrun frame checked).
